// File: rtl/acc_update_scheduler.sv
// Request sequencer for the feature accumulator: buffers row-update requests,
// waits out the bias-load boot phase, then issues one triggered update at a time.
module acc_update_scheduler #(
  parameter int ROW_W       = 7,
  parameter int MAX_ROW     = 120,
  parameter int DEPTH       = 8,
  parameter int BOOT_CYCLES = 8,
  parameter int TIMEOUT     = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ROW_W-1:0]           req_row,
  input  logic                       req_add,
  input  logic                       req_player,
  output logic                       acc_trigger,
  output logic [ROW_W-1:0]           acc_row,
  output logic                       acc_add,
  output logic                       acc_player,
  input  logic                       acc_finish,
  output logic                       busy,
  output logic                       drained,
  output logic [$clog2(DEPTH):0]     pending,
  output logic [15:0]                done_count,
  output logic                       err_range,
  output logic                       err_timeout,
  input  logic                       err_clr
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BOOT_W = $clog2(BOOT_CYCLES + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam int ENT_W  = ROW_W + 2;

  typedef enum logic [1:0] {ST_BOOT, ST_IDLE, ST_WAIT} state_t;

  state_t             state_reg, state_next;
  logic [BOOT_W-1:0]  boot_cnt_reg, boot_cnt_next;
  logic [TMO_W-1:0]   tmo_cnt_reg, tmo_cnt_next;
  logic               trigger_reg, trigger_next;
  logic [ROW_W-1:0]   acc_row_reg, acc_row_next;
  logic               acc_add_reg, acc_add_next;
  logic               acc_player_reg, acc_player_next;
  logic [15:0]        done_reg, done_next;
  logic               err_range_reg, err_range_next;
  logic               err_timeout_reg, err_timeout_next;

  logic [ENT_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;

  logic               accept, row_bad, push, pop, timeout_hit;

  assign req_ready = (count_reg < CNT_W'(DEPTH));
  assign accept    = req_valid && req_ready;
  assign row_bad   = (req_row > ROW_W'(MAX_ROW));
  // Out-of-range rows are consumed without back-pressure but never stored.
  assign push      = accept && !row_bad;

  always_comb begin
    state_next      = state_reg;
    boot_cnt_next   = boot_cnt_reg;
    tmo_cnt_next    = tmo_cnt_reg;
    trigger_next    = 1'b0;
    acc_row_next    = acc_row_reg;
    acc_add_next    = acc_add_reg;
    acc_player_next = acc_player_reg;
    done_next       = done_reg;
    pop             = 1'b0;
    timeout_hit     = 1'b0;
    case (state_reg)
      ST_BOOT: begin
        if (boot_cnt_reg == BOOT_W'(BOOT_CYCLES - 1)) begin
          state_next = ST_IDLE;
        end else begin
          boot_cnt_next = boot_cnt_reg + 1'b1;
        end
      end
      ST_IDLE: begin
        if (count_reg != '0) begin
          pop = 1'b1;
          {acc_row_next, acc_add_next, acc_player_next} = mem[rd_ptr_reg];
          trigger_next = 1'b1;
          tmo_cnt_next = '0;
          state_next   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Operands stay frozen: add/player are sampled only at completion.
        if (acc_finish) begin
          done_next  = done_reg + 16'd1;
          state_next = ST_IDLE;
        end else if (tmo_cnt_reg == TMO_W'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_next  = ST_IDLE;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_BOOT;
    endcase

    err_range_next   = (accept && row_bad) ? 1'b1 : (err_clr ? 1'b0 : err_range_reg);
    err_timeout_next = timeout_hit ? 1'b1 : (err_clr ? 1'b0 : err_timeout_reg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_BOOT;
      boot_cnt_reg    <= '0;
      tmo_cnt_reg     <= '0;
      trigger_reg     <= 1'b0;
      acc_row_reg     <= '0;
      acc_add_reg     <= 1'b0;
      acc_player_reg  <= 1'b0;
      done_reg        <= '0;
      err_range_reg   <= 1'b0;
      err_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      boot_cnt_reg    <= boot_cnt_next;
      tmo_cnt_reg     <= tmo_cnt_next;
      trigger_reg     <= trigger_next;
      acc_row_reg     <= acc_row_next;
      acc_add_reg     <= acc_add_next;
      acc_player_reg  <= acc_player_next;
      done_reg        <= done_next;
      err_range_reg   <= err_range_next;
      err_timeout_reg <= err_timeout_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset so it maps onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {req_row, req_add, req_player};
  end

  assign acc_trigger = trigger_reg;
  assign acc_row     = acc_row_reg;
  assign acc_add     = acc_add_reg;
  assign acc_player  = acc_player_reg;
  assign pending     = count_reg;
  assign done_count  = done_reg;
  assign err_range   = err_range_reg;
  assign err_timeout = err_timeout_reg;
  assign busy        = (state_reg != ST_IDLE) || (count_reg != '0);
  assign drained     = !busy;

endmodule

// File: tb/tb_acc_update_scheduler.sv
// Directed bench for acc_update_scheduler with a small accumulator model that
// finishes a configurable number of cycles after each trigger.
module tb_acc_update_scheduler;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_row;
  logic        req_add;
  logic        req_player;
  logic        acc_trigger;
  logic [6:0]  acc_row;
  logic        acc_add;
  logic        acc_player;
  logic        acc_finish;
  logic        busy;
  logic        drained;
  logic [3:0]  pending;
  logic [15:0] done_count;
  logic        err_range;
  logic        err_timeout;
  logic        err_clr;

  int tests_run;
  int tests_failed;

  int fin_delay;
  int fin_cnt;
  bit hold;
  bit prev_trig;
  logic [8:0] cap;
  logic [6:0] trig_q[$];

  acc_update_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_row(req_row),
    .req_add(req_add), .req_player(req_player),
    .acc_trigger(acc_trigger), .acc_row(acc_row), .acc_add(acc_add),
    .acc_player(acc_player), .acc_finish(acc_finish),
    .busy(busy), .drained(drained), .pending(pending), .done_count(done_count),
    .err_range(err_range), .err_timeout(err_timeout), .err_clr(err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Accumulator model, evaluated on the falling edge away from DUT updates.
  initial begin
    acc_finish = 1'b0;
    fin_cnt    = 0;
    prev_trig  = 1'b0;
    cap        = '0;
    forever begin
      @(negedge clk);
      acc_finish = 1'b0;
      if (!rst_n) begin
        fin_cnt   = 0;
        prev_trig = 1'b0;
      end else begin
        if (acc_trigger) begin
          check("trig_gap", int'(prev_trig), 0);
          trig_q.push_back(acc_row);
          cap     = {acc_row, acc_add, acc_player};
          fin_cnt = fin_delay;
        end else if (fin_cnt > 0) begin
          check("hold_ops", int'({acc_row, acc_add, acc_player}), int'(cap));
          if (!hold) begin
            fin_cnt--;
            if (fin_cnt == 0) acc_finish = 1'b1;
          end
        end
        prev_trig = acc_trigger;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [6:0] row, input logic add, input logic pl);
    req_valid  = 1'b1;
    req_row    = row;
    req_add    = add;
    req_player = pl;
    tick();
    req_valid  = 1'b0;
  endtask

  task automatic wait_trig(output int n);
    n = 0;
    while (!acc_trigger && n < 200) begin
      tick();
      n++;
    end
    check("trig_seen", int'(acc_trigger), 1);
  endtask

  task automatic wait_fin();
    int n = 0;
    while (!acc_finish && n < 200) begin
      tick();
      n++;
    end
    check("fin_seen", int'(acc_finish), 1);
  endtask

  task automatic wait_drained();
    int n = 0;
    while (!drained && n < 500) begin
      tick();
      n++;
    end
    check("drain_seen", int'(drained), 1);
  endtask

  initial begin
    int n;
    int p;
    tests_run    = 0;
    tests_failed = 0;
    fin_delay    = 3;
    hold         = 1'b0;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_row      = '0;
    req_add      = 1'b0;
    req_player   = 1'b0;
    err_clr      = 1'b0;

    // Reset values
    #2;
    check("rst_trig", int'(acc_trigger), 0);
    check("rst_row", int'(acc_row), 0);
    check("rst_ready", int'(req_ready), 1);
    check("rst_busy", int'(busy), 1);
    check("rst_drained", int'(drained), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_done", int'(done_count), 0);
    check("rst_errs", int'({err_range, err_timeout}), 0);
    tick();
    tick();

    // Boot phase: request row 3 right at release, no trigger for 8 cycles
    rst_n = 1'b1;
    push(7'd3, 1'b0, 1'b0);
    check("boot_pend", int'(pending), 1);
    for (int i = 0; i < 7; i++) begin
      check("boot_busy", int'(busy), 1);
      check("boot_notrig", int'(acc_trigger), 0);
      tick();
    end
    check("boot_notrig8", int'(acc_trigger), 0);
    tick();
    check("boot_trig", int'(acc_trigger), 1);
    check("boot_row", int'(acc_row), 3);
    wait_fin();
    check("boot_done", int'(done_count), 1);

    // Single update with add/player set and 1-cycle pulse
    wait_drained();
    push(7'd5, 1'b1, 1'b1);
    check("lat_pend", int'(pending), 1);
    check("lat_notrig", int'(acc_trigger), 0);
    tick();
    check("lat_trig", int'(acc_trigger), 1);
    check("op_row", int'(acc_row), 5);
    check("op_add", int'(acc_add), 1);
    check("op_player", int'(acc_player), 1);
    tick();
    check("pulse_one", int'(acc_trigger), 0);
    check("wait_busy", int'(busy), 1);
    check("wait_drained", int'(drained), 0);
    wait_fin();
    check("fin_drained", int'(drained), 1);
    check("fin_done", int'(done_count), 2);

    // Stalled accumulator, fill FIFO, overflow attempt, push+pop
    trig_q.delete();
    hold = 1'b1;
    push(7'd10, 1'b0, 1'b1);
    wait_trig(n);
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1;
      req_row   = 7'(20 + i);
      tick();
    end
    req_row = 7'd28;
    tick();
    tick();
    check("full_pend", int'(pending), 8);
    check("full_ready", int'(req_ready), 0);
    hold = 1'b0;
    n = 0;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    tick();
    req_valid = 1'b0;
    check("refill_pend", int'(pending), 8);
    wait_fin();
    tick();
    check("pop_pend", int'(pending), 7);
    wait_fin();
    push(7'd29, 1'b0, 1'b0);
    check("pushpop_pend", int'(pending), 7);
    check("pushpop_trig", int'(acc_trigger), 1);
    wait_drained();
    check("order_cnt", trig_q.size(), 11);
    for (int i = 0; i < 11 && i < trig_q.size(); i++) begin
      p = (i == 0) ? 10 : (i == 10) ? 29 : 19 + i;
      check("order_row", int'(trig_q[i]), p);
    end
    check("fill_done", int'(done_count), 13);

    // Range error: 121 dropped, 7 issued, then clear
    trig_q.delete();
    push(7'd121, 1'b1, 1'b0);
    check("rng_pend", int'(pending), 0);
    check("rng_err", int'(err_range), 1);
    push(7'd7, 1'b1, 1'b0);
    wait_drained();
    check("rng_cnt", trig_q.size(), 1);
    if (trig_q.size() > 0) check("rng_row", int'(trig_q[0]), 7);
    check("rng_sticky", int'(err_range), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("rng_clr", int'(err_range), 0);
    check("rng_done", int'(done_count), 14);

    // Timeout: accumulator never finishes
    fin_delay = 1000;
    push(7'd40, 1'b0, 1'b0);
    push(7'd41, 1'b0, 1'b0);
    check("tmo_trig", int'(acc_row), 40);
    n = 0;
    while (!err_timeout && n < 200) begin
      tick();
      n++;
    end
    check("tmo_cycles", n, 64);
    check("tmo_done", int'(done_count), 14);
    tick();
    check("tmo_next_trig", int'(acc_trigger), 1);
    check("tmo_next_row", int'(acc_row), 41);

    // Asynchronous reset mid-WAIT with 4 queued
    for (int i = 0; i < 4; i++) push(7'(50 + i), 1'b0, 1'b0);
    check("arst_pend_pre", int'(pending), 4);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_pend", int'(pending), 0);
    check("arst_row", int'(acc_row), 0);
    check("arst_busy", int'(busy), 1);
    check("arst_done", int'(done_count), 0);
    check("arst_tmo", int'(err_timeout), 0);
    check("arst_ready", int'(req_ready), 1);
    fin_delay = 3;
    tick();
    tick();
    trig_q.delete();
    rst_n = 1'b1;
    push(7'd60, 1'b1, 1'b1);
    wait_trig(n);
    check("reboot_lat", n, 8);
    check("reboot_row", int'(acc_row), 60);
    wait_drained();
    check("reboot_cnt", trig_q.size(), 1);
    check("reboot_done", int'(done_count), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
